// File: rtl/pool_addr_ctrl.sv
// Pooling address sequencer: steps a lane-parallel read window over each channel,
// handshakes with the RAM and pulses clear/accumulate/write/finish around it.
module pool_addr_ctrl #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned LANES    = 9,
   parameter int unsigned DEPTH    = 4096,
   parameter int unsigned CHANNELS = 1,
   localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_start,
   input  logic                      i_mode,
   input  logic                      i_validRam,
   output logic [LANES*ADDR_W-1:0]   o_addrRead,
   output logic [LANES-1:0]          o_laneMask,
   output logic                      o_startRam,
   output logic                      o_clearAcc,
   output logic                      o_accEnable,
   output logic                      o_writeResult,
   output logic [CH_W-1:0]           o_channel,
   output logic                      o_mode,
   output logic                      o_busy,
   output logic                      o_finish
);

   localparam int unsigned OFF_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_REQ, S_WAIT, S_ACC, S_NEXT, S_WRITE, S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [OFF_W-1:0]  r_offset;
   logic [CH_W-1:0]   r_channel;
   logic              r_mode;
   logic              w_last_grp;
   logic              w_last_ch;
   logic              w_lanes_on;

   assign w_last_grp = (32'(r_offset) + LANES) >= DEPTH;
   assign w_last_ch  = (32'(r_channel) == (CHANNELS - 1));
   assign w_lanes_on = (r_state == S_REQ) || (r_state == S_WAIT) ||
                       (r_state == S_ACC) || (r_state == S_NEXT);

   assign o_channel = r_channel;
   assign o_mode    = r_mode;

   // State register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next state and state-decoded pulses
   always_comb begin
      w_next        = r_state;
      o_startRam    = 1'b0;
      o_clearAcc    = 1'b0;
      o_accEnable   = 1'b0;
      o_writeResult = 1'b0;
      o_finish      = 1'b0;
      o_busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_CLEAR;
         S_CLEAR: begin o_clearAcc = 1'b1; w_next = S_REQ; end
         S_REQ:   begin o_startRam = 1'b1; w_next = S_WAIT; end
         S_WAIT:  if (i_validRam) w_next = S_ACC;
         S_ACC:   begin o_accEnable = 1'b1; w_next = S_NEXT; end
         S_NEXT:  w_next = w_last_grp ? S_WRITE : S_REQ;
         S_WRITE: begin
            o_writeResult = 1'b1;
            w_next        = w_last_ch ? S_DONE : S_CLEAR;
         end
         S_DONE:  begin o_finish = 1'b1; w_next = S_IDLE; end
         default: w_next = S_IDLE;
      endcase
   end

   // Offset, channel and mode registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_offset  <= '0;
         r_channel <= '0;
         r_mode    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_start) begin
               r_offset  <= '0;
               r_channel <= '0;
               r_mode    <= i_mode;
            end
            S_NEXT:  r_offset <= w_last_grp ? '0 : r_offset + OFF_W'(LANES);
            S_WRITE: if (!w_last_ch) r_channel <= r_channel + CH_W'(1);
            S_DONE:  r_channel <= '0;
            default: ;
         endcase
      end
   end

   // Lane addresses; lanes past the end of the channel read address 0 and are masked off
   always_comb begin
      logic [OFF_W-1:0] v_sum;
      v_sum      = '0;
      o_addrRead = '0;
      o_laneMask = '0;
      for (int k = 0; k < int'(LANES); k++) begin
         v_sum = r_offset + OFF_W'(k);
         if (w_lanes_on && (32'(v_sum) < DEPTH)) begin
            o_addrRead[k*ADDR_W +: ADDR_W] = v_sum[ADDR_W-1:0];
            o_laneMask[k]                  = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pool_addr_ctrl.sv
// Scoreboard bench: a per-run event list is generated from the channel/group rules and
// popped by monitors whenever a controller pulse appears; a RAM responder adds random latency.
module tb_pool_addr_ctrl;

   localparam int AW = 12;
   localparam int L0 = 9, D0 = 4096, C0 = 1;
   localparam int L1 = 4, D1 = 8,    C1 = 3;
   localparam int G0 = (D0 + L0 - 1) / L0;

   typedef struct {
      int           kind;   // 1 clear, 2 start, 3 acc, 4 write, 5 finish
      int           ch;
      logic [107:0] addr;
      logic [8:0]   mask;
      logic         mode;
   } ev_t;

   logic clk = 1'b0;
   logic i_reset;

   logic                 start0, mode0, vld0;
   logic [L0*AW-1:0]     addr0;
   logic [L0-1:0]        mask0;
   logic                 sr0, clr0, acc0, wr0, fin0, md0, busy0;
   logic [0:0]           ch0;

   logic                 start1, mode1, vld1;
   logic [L1*AW-1:0]     addr1;
   logic [L1-1:0]        mask1;
   logic                 sr1, clr1, acc1, wr1, fin1, md1, busy1;
   logic [1:0]           ch1;

   ev_t q0[$];
   ev_t q1[$];
   int  total = 0;
   int  bad   = 0;
   int  nstart = 0;
   int  stall_grp = -1;
   int  stall_len = 0;
   bit  hit_stall = 1'b0;
   bit  done1 = 1'b0;

   always #5 clk = ~clk;

   pool_addr_ctrl #(.ADDR_W(AW), .LANES(L0), .DEPTH(D0), .CHANNELS(C0)) u_dut0 (
      .i_clk(clk), .i_reset(i_reset), .i_start(start0), .i_mode(mode0), .i_validRam(vld0),
      .o_addrRead(addr0), .o_laneMask(mask0), .o_startRam(sr0), .o_clearAcc(clr0),
      .o_accEnable(acc0), .o_writeResult(wr0), .o_channel(ch0), .o_mode(md0),
      .o_busy(busy0), .o_finish(fin0));

   pool_addr_ctrl #(.ADDR_W(AW), .LANES(L1), .DEPTH(D1), .CHANNELS(C1)) u_dut1 (
      .i_clk(clk), .i_reset(i_reset), .i_start(start1), .i_mode(mode1), .i_validRam(vld1),
      .o_addrRead(addr1), .o_laneMask(mask1), .o_startRam(sr1), .o_clearAcc(clr1),
      .o_accEnable(acc1), .o_writeResult(wr1), .o_channel(ch1), .o_mode(md1),
      .o_busy(busy1), .o_finish(fin1));

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   task automatic push_ev(input int inst, input ev_t e);
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
   endtask

   // Expected pulse sequence of one run, straight from the channel/group rules
   task automatic gen_run(input int inst, input int l, input int d, input int c, input logic m);
      ev_t e;
      int  groups;
      groups = (d + l - 1) / l;
      for (int ch = 0; ch < c; ch++) begin
         e = '{kind: 1, ch: ch, addr: '0, mask: '0, mode: m};
         push_ev(inst, e);
         for (int g = 0; g < groups; g++) begin
            e.addr = '0;
            e.mask = '0;
            for (int k = 0; k < l; k++) begin
               if (g * l + k < d) begin
                  e.addr[k*AW +: AW] = AW'(g * l + k);
                  e.mask[k]          = 1'b1;
               end
            end
            e.kind = 2; push_ev(inst, e);
            e.kind = 3; push_ev(inst, e);
         end
         e = '{kind: 4, ch: ch, addr: '0, mask: '0, mode: m};
         push_ev(inst, e);
      end
      e = '{kind: 5, ch: c - 1, addr: '0, mask: '0, mode: m};
      push_ev(inst, e);
   endtask

   task automatic mon(input int inst, input logic [4:0] p, input logic [107:0] a,
                      input logic [8:0] m, input int ch, input logic md);
      ev_t e;
      int  kind;
      if (p == 5'd0) return;
      chk("pulse_onehot", $countones(p), 1);
      kind = p[4] ? 1 : p[3] ? 2 : p[2] ? 3 : p[1] ? 4 : 5;
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
         chk("unexpected_pulse_kind", kind, 0);
         return;
      end
      e = (inst == 0) ? q0.pop_front() : q1.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_channel", ch, e.ch);
      chk("event_addr", a, e.addr);
      chk("event_mask", m, e.mask);
      chk("event_mode", md, e.mode);
   endtask

   always @(negedge clk)
      mon(0, {clr0, sr0, acc0, wr0, fin0}, 108'(addr0), 9'(mask0), int'(ch0), md0);
   always @(negedge clk)
      mon(1, {clr1, sr1, acc1, wr1, fin1}, 108'(addr1), 9'(mask1), int'(ch1), md1);

   // RAM responder for instance 0: random read latency, valid deliberately high during REQ
   int           rcnt, grp_cur;
   bit           waiting, expect_acc;
   logic [107:0] held_a;
   logic [8:0]   held_m;
   always @(negedge clk) begin
      if (!i_reset) begin
         waiting = 1'b0; expect_acc = 1'b0; nstart = 0; vld0 = 1'b0;
      end else begin
         if (expect_acc) begin
            chk("acc_after_valid", acc0, 1);
            expect_acc = 1'b0;
         end
         if (sr0) begin
            grp_cur = nstart;
            nstart++;
            waiting = 1'b1;
            held_a  = 108'(addr0);
            held_m  = 9'(mask0);
            rcnt    = (grp_cur == stall_grp) ? stall_len : int'($urandom_range(0, 2));
            vld0    = 1'b1;
         end else if (waiting) begin
            chk("wait_addr_stable", 108'(addr0), held_a);
            chk("wait_mask_stable", 9'(mask0), held_m);
            chk("no_acc_before_valid", acc0, 0);
            if (grp_cur == stall_grp) hit_stall = 1'b1;
            if (rcnt == 0) begin
               vld0 = 1'b1; waiting = 1'b0; expect_acc = 1'b1;
            end else begin
               vld0 = 1'b0; rcnt--;
            end
         end else begin
            vld0 = 1'($urandom);
         end
      end
   end

   // Caller sits on a negedge; start is raised there and must be taken on the next edge
   task automatic run0(input logic m, input int sg, input int sl);
      stall_grp = sg; stall_len = sl; hit_stall = 1'b0; nstart = 0;
      gen_run(0, L0, D0, C0, m);
      start0 = 1'b1; mode0 = m;
      @(posedge clk); #1;
      chk("start_accepted", busy0, 1);
      start0 = 1'b0; mode0 = ~m;
   endtask

   task automatic wait_fin0(input bit poke_done);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20000 && !seen; c++) begin
         @(negedge clk);
         if (fin0) seen = 1'b1;
      end
      chk("finish0_seen", seen, 1);
      if (poke_done) start0 = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_finish", busy0, 0);
      chk("queue0_drained", q0.size(), 0);
      chk("group_count", nstart, G0);
      start0 = 1'b0;
   endtask

   task automatic chk_zero0(input string tag);
      chk({tag, "_busy"}, busy0, 0);
      chk({tag, "_addr"}, addr0, 0);
      chk({tag, "_mask"}, mask0, 0);
      chk({tag, "_pulses"}, {sr0, clr0, acc0, wr0, fin0}, 0);
      chk({tag, "_channel"}, ch0, 0);
      chk({tag, "_mode"}, md0, 0);
   endtask

   initial begin
      i_reset = 1'b0; start0 = 1'b0; mode0 = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_zero0("reset");
      @(negedge clk);
      i_reset = 1'b1;

      // Run 1: average mode, one long RAM stall at group 5
      run0(1'b0, 5, 20);
      wait_fin0(1'b0);

      // Run 2: max mode, start/mode toggled mid-run, start also held during DONE
      @(negedge clk);
      run0(1'b1, -1, 0);
      repeat (40) @(negedge clk);
      start0 = 1'b1; mode0 = 1'b0;
      repeat (4) @(negedge clk);
      start0 = 1'b0;
      wait_fin0(1'b1);

      // Run 3: aborted by reset while waiting on group 100
      @(negedge clk);
      run0(1'b1, 100, 10);
      for (int c = 0; c < 5000 && !hit_stall; c++) begin
         @(posedge clk); #1;
      end
      chk("reached_group100_wait", hit_stall, 1);
      chk("group100_busy", busy0, 1);
      i_reset = 1'b0;
      q0.delete();
      #1 chk_zero0("abort");
      repeat (2) @(negedge clk);
      chk_zero0("abort_hold");
      i_reset = 1'b1;

      // Run 4: fresh start after the abort
      run0(1'b0, -1, 0);
      wait_fin0(1'b0);

      for (int c = 0; c < 1000 && !done1; c++) @(posedge clk);
      chk("inst1_done", done1, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Instance 1: three channels of two full groups each, RAM always ready
   initial begin
      bit seen;
      vld1 = 1'b1; start1 = 1'b0; mode1 = 1'b0;
      @(posedge i_reset);
      @(negedge clk);
      gen_run(1, L1, D1, C1, 1'b1);
      start1 = 1'b1; mode1 = 1'b1;
      @(posedge clk); #1;
      chk("start1_accepted", busy1, 1);
      start1 = 1'b0; mode1 = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 500 && !seen; c++) begin
         @(negedge clk);
         if (fin1) seen = 1'b1;
      end
      chk("finish1_seen", seen, 1);
      @(posedge clk); #1;
      chk("queue1_drained", q1.size(), 0);
      chk("idle1_after_finish", busy1, 0);
      chk("idle1_channel", ch1, 0);
      done1 = 1'b1;
   end

endmodule

// File: doc/pool_addr_ctrl.md
POOL_ADDR_CTRL -- requirements
Module: pool_addr_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, width of one lane read address.
REQ-002 Parameter LANES, default 9, read lanes issued per group.
REQ-003 Parameter DEPTH, default 4096, elements per channel; legal range 1 <= DEPTH <= 2^ADDR_W.
REQ-004 Parameter CHANNELS, default 1, channels pooled per run; legal range >= 1.
REQ-005 i_clk  in  1  clock; all state updates on rising edge.
REQ-006 i_reset  in  1  reset, asynchronous, active-low.
REQ-007 i_start  in  1  run request; sampled in IDLE only.
REQ-008 i_mode  in  1  pooling mode, 0 average, 1 max; latched at start.
REQ-009 i_validRam  in  1  RAM read-data-valid; sampled in WAIT only.
REQ-010 o_addrRead  out  LANES*ADDR_W  packed lane addresses, lane k at bits [k*ADDR_W +: ADDR_W].
REQ-011 o_laneMask  out  LANES  bit k = 1 when lane k holds an in-range element.
REQ-012 o_startRam  out  1  one-cycle RAM read launch.
REQ-013 o_clearAcc  out  1  one-cycle accumulator clear, active-high.
REQ-014 o_accEnable  out  1  one-cycle accumulate of current group.
REQ-015 o_writeResult  out  1  one-cycle store of the finished channel result.
REQ-016 o_channel  out  max(1,$clog2(CHANNELS))  current channel index.
REQ-017 o_mode  out  1  latched mode; o_busy  out  1  high whenever state != IDLE; o_finish  out  1  one-cycle run done.

Function
REQ-018 States IDLE, CLEAR, REQ, WAIT, ACC, NEXT, WRITE, DONE; state register, offset counter (ADDR_W+1 bits), channel counter.
REQ-019 IDLE: i_start=1 -> CLEAR; offset=0, channel=0, o_mode<=i_mode; otherwise stay.
REQ-020 CLEAR: o_clearAcc=1 -> REQ.
REQ-021 REQ: o_startRam=1 -> WAIT; i_validRam in this cycle ignored.
REQ-022 WAIT: stay until i_validRam=1 -> ACC; no timeout.
REQ-023 ACC: o_accEnable=1 -> NEXT.
REQ-024 NEXT: last group (offset+LANES >= DEPTH) -> WRITE, offset<=0; else offset<=offset+LANES -> REQ.
REQ-025 WRITE: o_writeResult=1; channel==CHANNELS-1 -> DONE; else channel<=channel+1 -> CLEAR.
REQ-026 DONE: o_finish=1 -> IDLE; i_start in DONE ignored.
REQ-027 In REQ, WAIT, ACC, NEXT: lane k address = offset+k if offset+k < DEPTH, else 0; o_laneMask[k] = (offset+k < DEPTH); sums computed at ADDR_W+1 bits, no wrap.
REQ-028 In IDLE, CLEAR, WRITE, DONE: o_addrRead=0, o_laneMask=0.
REQ-029 Addresses and mask stable from REQ through NEXT of one group.
REQ-030 o_channel holds channel counter in all states; 0 in IDLE.
REQ-031 All pulse outputs combinational from state, exactly one cycle each, mutually exclusive.
REQ-032 i_start while busy ignored; o_mode unchanged until next IDLE->CLEAR.
REQ-033 Groups per channel = ceil(DEPTH/LANES); a full final group (DEPTH multiple of LANES) has all mask bits set.

Reset
REQ-034 i_reset=0 at any time, including mid-run, forces IDLE, offset=0, channel=0, o_mode=0, all outputs 0 asynchronously; no o_finish or o_writeResult emitted for the aborted run.
REQ-035 After i_reset release, first i_start accepted on the first rising edge.

Verification
REQ-036 Defaults, i_start, i_validRam one cycle after each o_startRam -> 456 o_startRam pulses, first group addresses 0..8 mask 9'h1FF, last group lane0=4095 mask 9'h001, one o_writeResult, o_finish 1 cycle later.
REQ-037 LANES=4, DEPTH=8, CHANNELS=3 -> per channel: clear, 2 groups (mask 4'hF), write; o_channel 0,1,2; single o_finish.
REQ-038 Hold i_validRam low 20 cycles in WAIT -> state, addresses, mask unchanged; no o_accEnable until valid.
REQ-039 i_mode=1 at start, i_mode=0 and i_start=1 mid-run -> o_mode stays 1, run unaffected.
REQ-040 Assert i_reset=0 during WAIT of group 100 -> outputs 0 immediately; fresh start restarts at address 0, channel 0.
REQ-041 i_validRam=1 during REQ only -> ignored; controller waits in WAIT.
